// File: rtl/nxm_wormhole_crossbar.sv
// Registered IN_N x OUT_M wormhole crossbar.
// Round-robin arbitration per output, packet locking, valid/ready on every port.
module nxm_wormhole_crossbar #(
   parameter int DATA_W = 10,
   parameter int IN_N   = 5,
   parameter int OUT_M  = 5,
   localparam int RT_W  = ($clog2(OUT_M) > 0) ? $clog2(OUT_M) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [IN_N*DATA_W-1:0]  data_i,
   input  logic [IN_N-1:0]         valid_i,
   input  logic [IN_N*RT_W-1:0]    route_i,
   output logic [IN_N-1:0]         ready_o,
   output logic [OUT_M*DATA_W-1:0] data_o,
   output logic [OUT_M-1:0]        valid_o,
   input  logic [OUT_M-1:0]        ready_i
);

   localparam int IW = (IN_N > 1) ? $clog2(IN_N) : 1;
   localparam logic [1:0] ID_HEAD = 2'b01;
   localparam logic [1:0] ID_TAIL = 2'b10;
   localparam logic [1:0] ID_SGL  = 2'b11;

   logic [DATA_W-1:0] flit [IN_N];
   logic [RT_W-1:0]   rt   [IN_N];
   logic [IN_N-1:0]   hd;
   logic [IN_N-1:0]   locked;

   logic [OUT_M-1:0]  busy_q, hold_q, vld_q;
   logic [OUT_M-1:0]  gv, load;
   logic [IW-1:0]     own_q [OUT_M];
   logic [IW-1:0]     rr_q  [OUT_M];
   logic [IW-1:0]     gi    [OUT_M];
   logic [DATA_W-1:0] gf    [OUT_M];
   logic [DATA_W-1:0] dat_q [OUT_M];

   always_comb begin
      locked = '0;
      for (int i = 0; i < IN_N; i++) begin
         flit[i] = data_i[DATA_W*i +: DATA_W];
         rt[i]   = route_i[RT_W*i +: RT_W];
         hd[i]   = (flit[i][DATA_W-1:DATA_W-2] == ID_HEAD) ||
                   (flit[i][DATA_W-1:DATA_W-2] == ID_SGL);
      end
      for (int o = 0; o < OUT_M; o++) begin
         if (busy_q[o]) locked[own_q[o]] = 1'b1;
      end
   end

   // Busy outputs follow their owner; idle ones scan from rr_q, skipping
   // the cycle right after a tail so each packet leaves a one-cycle gap.
   always_comb begin
      int j;
      j = 0;
      for (int o = 0; o < OUT_M; o++) begin
         gv[o] = 1'b0;
         gi[o] = own_q[o];
         if (!rst_ni) begin
            gv[o] = 1'b0;
         end else if (busy_q[o]) begin
            gv[o] = valid_i[own_q[o]] & ~hd[own_q[o]];
         end else if (!hold_q[o]) begin
            for (int k = 0; k < IN_N; k++) begin
               j = (int'(rr_q[o]) + k) % IN_N;
               if (!gv[o] && valid_i[j] && hd[j] && !locked[j] &&
                   rt[j] == RT_W'(o)) begin
                  gv[o] = 1'b1;
                  gi[o] = IW'(j);
               end
            end
         end
         gf[o]   = flit[gi[o]];
         load[o] = gv[o] & (~vld_q[o] | ready_i[o]);
      end
   end

   always_comb begin
      ready_o = '0;
      for (int o = 0; o < OUT_M; o++) begin
         if (load[o]) ready_o[gi[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
         hold_q <= '0;
         vld_q  <= '0;
         for (int o = 0; o < OUT_M; o++) begin
            own_q[o] <= '0;
            rr_q[o]  <= '0;
            dat_q[o] <= '0;
         end
      end else begin
         for (int o = 0; o < OUT_M; o++) begin
            hold_q[o] <= 1'b0;
            if (load[o]) begin
               dat_q[o] <= gf[o];
               vld_q[o] <= 1'b1;
               if (busy_q[o]) begin
                  if (gf[o][DATA_W-1:DATA_W-2] == ID_TAIL) begin
                     busy_q[o] <= 1'b0;
                     hold_q[o] <= 1'b1;
                  end
               end else begin
                  rr_q[o] <= (gi[o] == IW'(IN_N-1)) ? '0 : gi[o] + 1'b1;
                  if (gf[o][DATA_W-1:DATA_W-2] == ID_HEAD) begin
                     busy_q[o] <= 1'b1;
                     own_q[o]  <= gi[o];
                  end
               end
            end else if (ready_i[o]) begin
               vld_q[o] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      for (int o = 0; o < OUT_M; o++) begin
         data_o[DATA_W*o +: DATA_W] = dat_q[o];
      end
      valid_o = vld_q;
   end

endmodule

// File: tb/tb_nxm_wormhole_crossbar.sv
// Directed testbench for nxm_wormhole_crossbar (5x5, 10-bit flits).
// Each task drives one scenario and checks against hand-computed values.
module tb_nxm_wormhole_crossbar;

   logic        clk_i;
   logic        rst_ni;
   logic [49:0] data_i;
   logic [4:0]  valid_i;
   logic [14:0] route_i;
   logic [4:0]  ready_o;
   logic [49:0] data_o;
   logic [4:0]  valid_o;
   logic [4:0]  ready_i;

   int checks;
   int failures;

   nxm_wormhole_crossbar #(.DATA_W(10), .IN_N(5), .OUT_M(5)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .data_i (data_i),
      .valid_i(valid_i),
      .route_i(route_i),
      .ready_o(ready_o),
      .data_o (data_o),
      .valid_o(valid_o),
      .ready_i(ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic set_in(input int i, input logic [1:0] id,
                         input logic [7:0] pl, input int rt,
                         input logic v);
      data_i[10*i +: 10] = {id, pl};
      route_i[3*i +: 3]  = 3'(rt);
      valid_i[i]         = v;
   endtask

   function automatic logic [9:0] dout(input int o);
      return data_o[10*o +: 10];
   endfunction

   function automatic logic [1:0] idf(input int f);
      if (f == 0) return 2'b01;
      if (f == 1) return 2'b00;
      return 2'b10;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      data_i  = '0;
      valid_i = '0;
      route_i = '0;
   endtask

   task automatic do_reset();
      rst_ni  = 1'b0;
      ready_i = '1;
      clr();
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni  = 1'b0;
      ready_i = '1;
      for (int i = 0; i < 5; i++) set_in(i, 2'b11, 8'(i), 0, 1'b1);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      checks++;
      if (valid_o !== 5'b0) begin
         failures++;
         $display("FAIL rst_valid got=%b exp=%b", valid_o, 5'b0);
      end
      checks++;
      if (ready_o !== 5'b0) begin
         failures++;
         $display("FAIL rst_ready got=%b exp=%b", ready_o, 5'b0);
      end
      checks++;
      if (data_o !== 50'b0) begin
         failures++;
         $display("FAIL rst_data got=%h exp=0", data_o);
      end
      rst_ni = 1'b1;
      #1;
      checks++;
      if (ready_o !== 5'b00001) begin
         failures++;
         $display("FAIL rel_ready got=%b exp=%b", ready_o, 5'b00001);
      end
      step();
      checks++;
      if (valid_o !== 5'b00001 || dout(0) !== 10'h300) begin
         failures++;
         $display("FAIL rel_out got=%b/%h exp=00001/300", valid_o, dout(0));
      end
      checks++;
      if (ready_o !== 5'b00010) begin
         failures++;
         $display("FAIL rr_next got=%b exp=%b", ready_o, 5'b00010);
      end
      clr();
   endtask

   task automatic test_single_path();
      do_reset();
      set_in(0, 2'b11, 8'hAB, 2, 1'b1);
      #1;
      checks++;
      if (ready_o !== 5'b00001) begin
         failures++;
         $display("FAIL sp_ready got=%b exp=%b", ready_o, 5'b00001);
      end
      step();
      clr();
      checks++;
      if (valid_o !== 5'b00100) begin
         failures++;
         $display("FAIL sp_valid got=%b exp=%b", valid_o, 5'b00100);
      end
      checks++;
      if (dout(2) !== 10'h3AB) begin
         failures++;
         $display("FAIL sp_data got=%h exp=%h", dout(2), 10'h3AB);
      end
   endtask

   task automatic test_rr_fairness();
      int fi [5];
      logic [4:0] rdy;
      logic [9:0] exp;
      logic       ev;
      int p, f;
      do_reset();
      for (int i = 0; i < 5; i++) fi[i] = 0;
      for (int c = 1; c <= 24; c++) begin
         for (int i = 0; i < 5; i++) begin
            if (fi[i] < 3) set_in(i, idf(fi[i]), {4'(i), 4'(fi[i])}, 1, 1'b1);
            else set_in(i, 2'b00, 8'h00, 0, 1'b0);
         end
         #1;
         rdy = ready_o;
         step();
         for (int i = 0; i < 5; i++) if (rdy[i]) fi[i]++;
         ev = (c <= 19) && (c % 4 != 0);
         checks++;
         if (valid_o !== {3'b000, ev, 1'b0}) begin
            failures++;
            $display("FAIL rr_valid c=%0d got=%b exp=%b", c, valid_o, {3'b000, ev, 1'b0});
         end
         if (ev) begin
            p = (c - 1) / 4;
            f = (c - 1) % 4;
            exp = {idf(f), 4'(p), 4'(f)};
            checks++;
            if (dout(1) !== exp) begin
               failures++;
               $display("FAIL rr_data c=%0d got=%h exp=%h", c, dout(1), exp);
            end
         end
      end
      clr();
   endtask

   task automatic test_backpressure();
      logic [9:0] fl [4];
      logic [7:0] q [3];
      logic [4:0] rdy;
      int fi, n;
      fl[0] = 10'h111;
      fl[1] = 10'h022;
      fl[2] = 10'h033;
      fl[3] = 10'h244;
      do_reset();
      set_in(2, 2'b01, 8'h11, 0, 1'b1);
      #1;
      checks++;
      if (ready_o !== 5'b00100) begin
         failures++;
         $display("FAIL bp_first_ready got=%b exp=%b", ready_o, 5'b00100);
      end
      step();
      checks++;
      if (valid_o[0] !== 1'b1 || dout(0) !== 10'h111) begin
         failures++;
         $display("FAIL bp_first got=%b/%h exp=1/111", valid_o[0], dout(0));
      end
      ready_i[0] = 1'b0;
      set_in(2, 2'b00, 8'h22, 0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (ready_o[2] !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall_ready k=%0d got=%b exp=0", k, ready_o[2]);
         end
         step();
         checks++;
         if (valid_o[0] !== 1'b1 || dout(0) !== 10'h111) begin
            failures++;
            $display("FAIL bp_hold k=%0d got=%b/%h exp=1/111", k, valid_o[0], dout(0));
         end
      end
      ready_i[0] = 1'b1;
      fi = 1;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         if (fi < 4) set_in(2, fl[fi][9:8], fl[fi][7:0], 0, 1'b1);
         else set_in(2, 2'b00, 8'h00, 0, 1'b0);
         #1;
         rdy = ready_o;
         step();
         if (rdy[2]) fi++;
         if (valid_o[0] && n < 3) begin
            q[n] = dout(0)[7:0];
            n++;
         end
      end
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=3", n);
      end
      for (int k = 0; k < n; k++) begin
         checks++;
         if (q[k] !== fl[k+1][7:0]) begin
            failures++;
            $display("FAIL bp_order k=%0d got=%h exp=%h", k, q[k], fl[k+1][7:0]);
         end
      end
      clr();
   endtask

   task automatic test_parallel();
      do_reset();
      for (int i = 0; i < 5; i++) set_in(i, 2'b11, 8'h50 + 8'(i), 4 - i, 1'b1);
      #1;
      checks++;
      if (ready_o !== 5'h1F) begin
         failures++;
         $display("FAIL par_ready got=%b exp=11111", ready_o);
      end
      step();
      clr();
      checks++;
      if (valid_o !== 5'h1F) begin
         failures++;
         $display("FAIL par_valid got=%b exp=11111", valid_o);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (dout(4 - i) !== {2'b11, 8'h50 + 8'(i)}) begin
            failures++;
            $display("FAIL par_data o=%0d got=%h exp=%h", 4 - i, dout(4 - i), {2'b11, 8'h50 + 8'(i)});
         end
      end
      set_in(0, 2'b00, 8'h77, 0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (ready_o !== 5'b0) begin
            failures++;
            $display("FAIL orphan_ready k=%0d got=%b exp=00000", k, ready_o);
         end
         step();
         checks++;
         if (valid_o !== 5'b0) begin
            failures++;
            $display("FAIL orphan_valid k=%0d got=%b exp=00000", k, valid_o);
         end
      end
      clr();
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      set_in(1, 2'b01, 8'h61, 3, 1'b1);
      step();
      set_in(1, 2'b00, 8'h62, 3, 1'b1);
      #1;
      checks++;
      if (ready_o !== 5'b00010) begin
         failures++;
         $display("FAIL mid_body_ready got=%b exp=00010", ready_o);
      end
      step();
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (valid_o !== 5'b0) begin
         failures++;
         $display("FAIL mid_async_valid got=%b exp=00000", valid_o);
      end
      checks++;
      if (ready_o !== 5'b0) begin
         failures++;
         $display("FAIL mid_async_ready got=%b exp=00000", ready_o);
      end
      clr();
      set_in(3, 2'b01, 8'h63, 3, 1'b1);
      set_in(1, 2'b01, 8'h64, 2, 1'b1);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b1;
      #1;
      checks++;
      if (ready_o !== 5'b01010) begin
         failures++;
         $display("FAIL mid_rel_ready got=%b exp=01010", ready_o);
      end
      step();
      clr();
      checks++;
      if (valid_o !== 5'b01100 || dout(3) !== 10'h163 || dout(2) !== 10'h164) begin
         failures++;
         $display("FAIL mid_rel_out got=%b/%h/%h exp=01100/163/164", valid_o, dout(3), dout(2));
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_ni   = 1'b0;
      ready_i  = '1;
      clr();
      test_reset();
      test_single_path();
      test_rr_fairness();
      test_backpressure();
      test_parallel();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
